// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and a word-addressed data memory.
// Sub-word stores run as read-modify-write; bad requests answer with an error.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, RMW_RD, RMW_WR, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        legal, misal, bad;
  logic        ld_ok, sw_ok, sub_ok;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_fmt;
  logic [31:0] merged;

  always_comb begin
    legal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_we;
      default:                legal = 1'b0;
    endcase
    misal = ((req_funct3[1:0] == 2'b01) & req_addr[0])
          | ((req_funct3 == 3'b010) & (req_addr[1:0] != 2'b00));
    bad    = ~legal | misal;
    ld_ok  = ~bad & ~req_we;
    sw_ok  = ~bad & req_we & req_funct3[1];
    sub_ok = ~bad & req_we & ~req_funct3[1];
  end

  always_comb begin
    lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (f3_q)
      3'b000:  ld_fmt = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_fmt = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_fmt = {24'h0, lane_b};
      3'b101:  ld_fmt = {16'h0, lane_h};
      default: ld_fmt = mem_rdata;
    endcase
    merged = mem_rdata;
    if (f3_q[0])
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = 32'h0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          unique case (1'b1)
            ld_ok:   state_d = LOAD;
            sw_ok:   state_d = WRITE;
            sub_ok:  state_d = RMW_RD;
            default: state_d = ERR;
          endcase
        end
      end
      LOAD: begin
        rdata_d = ld_fmt;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      RMW_RD: begin
        merge_d = merged;
        state_d = RMW_WR;
      end
      WRITE, RMW_WR: begin
        valid_d = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        valid_d = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      f3_q    <= 3'b000;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Memory side depends only on state and the registered request.
  always_comb begin
    req_ready = (state_q == IDLE) & ~rst;
    MemRead   = (state_q == LOAD) | (state_q == RMW_RD);
    MemWrite  = (state_q == WRITE) | (state_q == RMW_WR);
    mem_addr  = (MemRead | MemWrite) ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_wdata = 32'h0;
    if (state_q == WRITE)  mem_wdata = wdata_q;
    if (state_q == RMW_WR) mem_wdata = merge_q;
  end

  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a small behavioural data memory.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:15];
  logic        load_en;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8081F27F;
    end else if (MemWrite) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[5:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          due;
    string       nm;
  } exp_t;
  exp_t q[$];

  int errs = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  logic [31:0] last_wdata = 32'h0;

  always @(negedge clk) begin
    if (!rst) begin
      if (MemRead) rd_cnt++;
      if (MemWrite) begin
        wr_cnt++;
        last_wdata = mem_wdata;
      end
      if (MemRead && MemWrite) both_cnt++;
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_resp", resp_rdata, 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk(resp_rdata == e.rd, {e.nm, "_rdata"}, resp_rdata, e.rd);
          chk(resp_err == e.err, {e.nm, "_err"},
              {31'h0, resp_err}, {31'h0, e.err});
          chk(cyc == e.due, {e.nm, "_latency"}, cyc, e.due);
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        exp_t e;
        e = q.pop_front();
        chk(1'b0, {e.nm, "_timeout"}, cyc, e.due);
      end
    end
  end

  task automatic issue(input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit push, input bit err,
                       input logic [31:0] rd, input int lat,
                       input string nm, output int acc);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk(1'b0, {nm, "_accept"}, 32'h0, 32'h1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) q.push_back('{err, rd, cyc + lat, nm});
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  int acc, acc2;
  int r0, w0;

  initial begin
    rst = 1'b1;
    load_en = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk(req_ready == 1'b0, "rst_ready", {31'h0, req_ready}, 32'h0);
    chk({resp_valid, resp_err, MemRead, MemWrite} == 4'b0, "rst_ctrl",
        {28'h0, resp_valid, resp_err, MemRead, MemWrite}, 32'h0);
    chk((mem_addr | mem_wdata | resp_rdata) == 32'h0, "rst_data",
        mem_addr | mem_wdata | resp_rdata, 32'h0);
    load_en = 1'b0;
    rst = 1'b0;
    #1;
    chk(req_ready == 1'b1, "ready_after_rst", {31'h0, req_ready}, 32'h1);

    issue(1'b1, 3'b000, 32'h11, 32'h123456AA, 1'b0, 1'b0, 32'h0, 2,
          "sb_abort", acc);
    #2;
    chk(MemRead == 1'b1, "rmw_rd_read", {31'h0, MemRead}, 32'h1);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk({MemRead, MemWrite, req_ready} == 3'b000, "midrst_strobes",
        {29'h0, MemRead, MemWrite, req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk(mem[4] == 32'h8081F27F, "abort_mem", mem[4], 32'h8081F27F);

    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0, 32'h8081F27F, 1, "lw10", acc);
    drain();
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80, 1, "lb13", acc);
    drain();
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 1'b0, 32'h00000080, 1, "lbu13", acc);
    drain();
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 1'b0, 32'hFFFF8081, 1, "lh12", acc);
    drain();
    issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0000F27F, 1, "lhu10", acc);
    drain();

    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 3'b000, 32'h11, 32'h123456AA, 1'b1, 1'b0, 32'h0, 2, "sb11", acc);
    drain();
    chk(rd_cnt - r0 == 1, "sb_reads", rd_cnt - r0, 32'd1);
    chk(wr_cnt - w0 == 1, "sb_writes", wr_cnt - w0, 32'd1);
    chk(last_wdata == 32'h8081AA7F, "sb_wdata", last_wdata, 32'h8081AA7F);

    issue(1'b1, 3'b000, 32'h10, 32'h00000055, 1'b1, 1'b0, 32'h0, 2, "b2b_sb", acc);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0, 32'h8081AA55, 1, "b2b_lw", acc2);
    drain();
    chk(acc2 == acc + 3, "b2b_accept", acc2, acc + 3);

    issue(1'b1, 3'b001, 32'h12, 32'h00001234, 1'b1, 1'b0, 32'h0, 2, "sh12", acc);
    drain();
    chk(mem[4] == 32'h1234AA55, "sh_mem", mem[4], 32'h1234AA55);

    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1, "sw14", acc);
    drain();
    chk(rd_cnt - r0 == 0, "sw_reads", rd_cnt - r0, 32'd0);
    chk(wr_cnt - w0 == 1, "sw_writes", wr_cnt - w0, 32'd1);
    issue(1'b0, 3'b010, 32'h14, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1, "lw14", acc);
    drain();

    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 1'b1, 32'h0, 1, "err_lw12", acc);
    drain();
    issue(1'b1, 3'b001, 32'h11, 32'hFFFF, 1'b1, 1'b1, 32'h0, 1, "err_sh11", acc);
    drain();
    issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0, 1, "err_f3", acc);
    drain();
    chk((rd_cnt - r0) + (wr_cnt - w0) == 0, "err_strobes",
        (rd_cnt - r0) + (wr_cnt - w0), 32'd0);
    chk(mem[4] == 32'h1234AA55, "err_mem", mem[4], 32'h1234AA55);
    chk(both_cnt == 0, "rd_wr_overlap", both_cnt, 32'd0);
    chk(q.size() == 0, "queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
